bsg_arb_round_robin_burst: RTL and testbench

Round-robin arbiter that shares one downstream datapath port among `inputs_p` requesters, granting it in bounded bursts. It wraps a lowest-index one-hot priority encoder with a rotating priority pointer, a registered grant and a beat counter. It sits between requester queues and a shared consumer that accepts beats with a `yumi` handshake.

---
 rtl/bsg_arb_round_robin_burst.sv | 118 +++++++++++
 tb/tb_bsg_arb_round_robin_burst.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_arb_round_robin_burst.sv
// Round-robin burst arbiter: a rotating-priority one-hot pick of one requester,
// which then owns the shared port for up to max_burst_p accepted beats.
module bsg_arb_round_robin_burst #(
  parameter int inputs_p     = 16,
  parameter int max_burst_p  = 4,
  parameter int lg_inputs_lp = $clog2(inputs_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [inputs_p-1:0]     reqs_i,
  input  logic                    last_i,
  input  logic                    yumi_i,
  output logic [inputs_p-1:0]     grants_o,
  output logic [lg_inputs_lp-1:0] tag_o,
  output logic                    v_o,
  output logic                    last_o
);

  localparam int cnt_w_lp = (max_burst_p > 1) ? $clog2(max_burst_p) : 1;
  localparam logic [cnt_w_lp-1:0]     cnt_max_lp = cnt_w_lp'(max_burst_p - 1);
  localparam logic [lg_inputs_lp-1:0] ptr_top_lp = lg_inputs_lp'(inputs_p - 1);
  localparam logic [lg_inputs_lp:0]   n_lp       = (lg_inputs_lp + 1)'(inputs_p);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [inputs_p-1:0]     grants_q, grants_d;
  logic [lg_inputs_lp-1:0] tag_q, tag_d;
  logic [lg_inputs_lp-1:0] ptr_q, ptr_d;
  logic [cnt_w_lp-1:0]     beat_cnt_q, beat_cnt_d;

  logic [lg_inputs_lp-1:0] start;
  logic [lg_inputs_lp:0]   start_ext;
  logic [2*inputs_p-1:0]   reqs_dbl;
  logic [inputs_p-1:0]     reqs_rot;
  logic [inputs_p-1:0]     rot_onehot;
  logic [lg_inputs_lp-1:0] idx_terms [inputs_p];
  logic [lg_inputs_lp-1:0] rot_idx;
  logic [lg_inputs_lp:0]   win_sum;
  logic [lg_inputs_lp-1:0] win_idx;
  logic [inputs_p-1:0]     win_onehot;

  // Search starts one past the last winner, so the last winner ranks lowest.
  assign start     = (ptr_q == ptr_top_lp) ? '0 : ptr_q + lg_inputs_lp'(1);
  assign start_ext = {1'b0, start};
  assign reqs_dbl  = {reqs_i, reqs_i};
  assign reqs_rot  = reqs_dbl[start_ext +: inputs_p];
  assign rot_onehot = reqs_rot & (~reqs_rot + inputs_p'(1));

  for (genvar gi = 0; gi < inputs_p; gi++) begin : g_idx
    assign idx_terms[gi] = rot_onehot[gi] ? lg_inputs_lp'(gi) : '0;
  end

  always_comb begin
    rot_idx = '0;
    for (int i = 0; i < inputs_p; i++) begin
      rot_idx = rot_idx | idx_terms[i];
    end
  end

  // Undo the rotation: rotated position k is requester (start + k) mod inputs_p.
  assign win_sum    = start_ext + {1'b0, rot_idx};
  assign win_idx    = lg_inputs_lp'((win_sum >= n_lp) ? win_sum - n_lp : win_sum);
  assign win_onehot = inputs_p'(1) << win_idx;

  assign v_o      = (state_q == GRANT);
  assign last_o   = v_o & (last_i | (beat_cnt_q == cnt_max_lp));
  assign grants_o = grants_q;
  assign tag_o    = tag_q;

  always_comb begin
    state_d    = state_q;
    grants_d   = grants_q;
    tag_d      = tag_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|reqs_i) begin
          state_d    = GRANT;
          grants_d   = win_onehot;
          tag_d      = win_idx;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (yumi_i) begin
          if (last_o) begin
            state_d    = IDLE;
            ptr_d      = tag_q;
            grants_d   = '0;
            tag_d      = '0;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + cnt_w_lp'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      grants_q   <= '0;
      tag_q      <= '0;
      ptr_q      <= ptr_top_lp;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grants_q   <= grants_d;
      tag_q      <= tag_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_bsg_arb_round_robin_burst.sv
// Bench for bsg_arb_round_robin_burst: directed table, corner sequences and
// random traffic checked against a behavioural owner/pointer model.
module tb_bsg_arb_round_robin_burst;

  localparam int N    = 16;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N-1:0]  reqs;
  logic          last;
  logic          yumi;
  logic [N-1:0]  grants;
  logic [3:0]    tag;
  logic          v;
  logic          last_o;

  bsg_arb_round_robin_burst #(.inputs_p(N), .max_burst_p(MAXB)) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .reqs_i   (reqs),
    .last_i   (last),
    .yumi_i   (yumi),
    .grants_o (grants),
    .tag_o    (tag),
    .v_o      (v),
    .last_o   (last_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: who owns the port, how many beats it has had, and the last winner.
  bit m_busy;
  int m_owner, m_beats, m_ptr;

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_beats = 0;
    m_ptr   = N - 1;
  endfunction

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  logic [N-1:0] o_grants;
  logic [3:0]   o_tag;
  logic         o_v, o_last;

  task automatic step(input logic [N-1:0] r, input logic l, input logic y);
    logic e_last;
    int   w;
    @(negedge clk);
    reqs = r; last = l; yumi = y;
    #1;
    o_grants = grants; o_tag = tag; o_v = v; o_last = last_o;
    e_last = m_busy && (l || (m_beats == MAXB - 1));
    chk("model_v", 32'(o_v), 32'(m_busy));
    chk("model_grants", 32'(o_grants), m_busy ? (32'h1 << m_owner) : 32'h0);
    chk("model_tag", 32'(o_tag), m_busy ? 32'(m_owner) : 32'h0);
    chk("model_last", 32'(o_last), 32'(e_last));
    assert (!(y && !m_busy)) else $error("protocol: yumi with no valid beat");
    if (m_busy) assert (r[m_owner]) else $error("protocol: owner dropped its request");
    @(posedge clk);
    if (!m_busy) begin
      w = pick(r);
      if (w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_beats = 0;
      end
    end else if (y) begin
      if (e_last) begin
        $display("burst done: owner %0d, %0d beats", m_owner, m_beats + 1);
        m_busy = 1'b0; m_ptr = m_owner; m_beats = 0;
      end else begin
        m_beats++;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] r;
    logic         l;
    logic         y;
    logic         ev;
    logic [N-1:0] eg;
    logic [3:0]   et;
    logic         el;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k, prev;
    int wexp [3];
    logic [N-1:0] rr;

    tbl[0] = '{16'h8001, 1'b1, 1'b0, 1'b0, 16'h0000, 4'd0,  1'b0};
    tbl[1] = '{16'h8001, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd0,  1'b1};
    tbl[2] = '{16'h8001, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0,  1'b0};
    tbl[3] = '{16'h8001, 1'b0, 1'b1, 1'b1, 16'h8000, 4'd15, 1'b0};
    tbl[4] = '{16'h8001, 1'b0, 1'b0, 1'b1, 16'h8000, 4'd15, 1'b0};
    tbl[5] = '{16'h8001, 1'b1, 1'b1, 1'b1, 16'h8000, 4'd15, 1'b1};
    tbl[6] = '{16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd0,  1'b0};

    // Reset and idle
    reset_n = 1'b0; reqs = '0; last = 1'b0; yumi = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_v", 32'(v), 32'h0);
    chk("rst_grants", 32'(grants), 32'h0);
    chk("rst_tag", 32'(tag), 32'h0);
    chk("rst_last", 32'(last_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, 1'b0);
      chk("idle_v", 32'(o_v), 32'h0);
      chk("idle_grants", 32'(o_grants), 32'h0);
      chk("idle_tag", 32'(o_tag), 32'h0);
    end

    // Directed table
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].r, tbl[i].l, tbl[i].y);
      chk($sformatf("tbl%0d_v", i), 32'(o_v), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_grants", i), 32'(o_grants), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_tag", i), 32'(o_tag), 32'(tbl[i].et));
      chk($sformatf("tbl%0d_last", i), 32'(o_last), 32'(tbl[i].el));
    end

    // Fairness: all requesting, single-beat bursts
    k = 0; prev = 0;
    for (int c = 0; c < 60 && k < 17; c++) begin
      step(16'hFFFF, 1'b1, m_busy);
      if (o_v) begin
        chk("fair_tag", 32'(o_tag), 32'(k % N));
        if (k > 0) chk("fair_spacing", 32'(c - prev), 32'd2);
        prev = c;
        k++;
      end
    end
    chk("fair_count", 32'(k), 32'd17);

    // Pointer wrap after owner 14
    step(16'h4000, 1'b1, 1'b0);
    step(16'h4000, 1'b1, 1'b1);
    chk("wrap_owner14", 32'(o_tag), 32'd14);
    wexp = '{0, 1, 14};
    k = 0;
    for (int c = 0; c < 12 && k < 3; c++) begin
      step(16'h4003, 1'b1, m_busy);
      if (o_v) begin
        chk("wrap_tag", 32'(o_tag), 32'(wexp[k]));
        k++;
      end
    end
    chk("wrap_count", 32'(k), 32'd3);

    // Burst cap: owner 5 never sets last
    step(16'h0020, 1'b0, 1'b0);
    for (int b = 0; b < MAXB; b++) begin
      step(16'h0020, 1'b0, 1'b1);
      chk("cap_v", 32'(o_v), 32'h1);
      chk("cap_tag", 32'(o_tag), 32'd5);
      chk("cap_last", 32'(o_last), 32'(b == MAXB - 1));
    end
    step('0, 1'b0, 1'b0);
    chk("cap_bubble_v", 32'(o_v), 32'h0);

    // Stall then early last: owner 3
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b1);
    chk("stall_beat1_last", 32'(o_last), 32'h0);
    for (int s = 0; s < 5; s++) begin
      step(16'h0008, 1'b0, 1'b0);
      chk("stall_grants", 32'(o_grants), 32'h0008);
    end
    step(16'h0008, 1'b1, 1'b1);
    chk("stall_end_last", 32'(o_last), 32'h1);
    step('0, 1'b0, 1'b0);
    chk("stall_bubble_v", 32'(o_v), 32'h0);
    step(16'hFFFF, 1'b0, 1'b0);
    step(16'hFFFF, 1'b1, 1'b1);
    chk("stall_ptr_next", 32'(o_tag), 32'd4);

    // Reset during beat 2 of owner 7
    step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 1'b1);
    @(negedge clk);
    reqs = 16'h0080; last = 1'b1; yumi = 1'b0;
    #1;
    chk("mid_pre_v", 32'(v), 32'h1);
    chk("mid_pre_tag", 32'(tag), 32'd7);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_v", 32'(v), 32'h0);
    chk("mid_rst_grants", 32'(grants), 32'h0);
    chk("mid_rst_tag", 32'(tag), 32'h0);
    chk("mid_rst_last", 32'(last_o), 32'h0);
    model_reset();
    reqs = '0; last = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step(16'h0081, 1'b0, 1'b0);
    step(16'h0081, 1'b1, 1'b1);
    chk("mid_after_grants", 32'(o_grants), 32'h0001);
    chk("mid_after_tag", 32'(o_tag), 32'h0);

    // Random legal traffic
    for (int c = 0; c < 400; c++) begin
      rr = N'($urandom);
      if ($urandom_range(0, 3) == 0) rr = '0;
      if (m_busy) rr[m_owner] = 1'b1;
      step(rr, ($urandom_range(0, 3) == 0), m_busy ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
